// File: rtl/memory_controller_pkg.sv
// rtl/memory_controller_pkg.sv - shared types, constants and state encodings for the memory controller
package memory_controller_pkg;

  typedef logic [31:0] ADDR_TYPE;
  typedef logic [31:0] INST_TYPE;

  localparam ADDR_TYPE BLANK_ADDR = 32'h0000_0000;
  localparam logic     TRUE       = 1'b1;
  localparam logic     FALSE      = 1'b0;

  // LSB access length encoding (2'd2 is not a legal request)
  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_READ  = 2'd1,
    LS_READ  = 2'd2,
    LS_WRITE = 2'd3
  } mc_state_t;

  typedef enum logic {
    GRANT_IF  = 1'b0,
    GRANT_LSB = 1'b1
  } grant_t;

  // Byte count of an LSB request; the illegal code falls back to a word.
  function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
    case (len)
      LEN_B:   return 3'd1;
      LEN_H:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/memory_controller_if.sv
// rtl/memory_controller_if.sv - byte-wide RAM/IO port plus fetcher and LSB request handshakes
// Signals:
//   mem_din/mem_dout/mem_a/mem_wr : RAM byte port (read data valid one cycle after its address)
//   io_buffer_full                : UART buffer full, stalls IO writes
//   if_to_mc_* / mc_to_if_*       : instruction fetch request (level) and done pulse + instruction
//   lsb_to_mc_* / mc_to_lsb_*     : load/store request (level) and done pulse + load data
// Modports: master = memory controller, slave = RAM and requesters.
interface memory_controller_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [7:0]            mem_din;
  logic [7:0]            mem_dout;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic                  mem_wr;
  logic                  io_buffer_full;

  logic                  if_to_mc_ready;
  logic [ADDR_WIDTH-1:0] if_to_mc_PC;
  logic                  mc_to_if_ready;
  logic [31:0]           mc_to_if_inst;

  logic                  lsb_to_mc_valid;
  logic                  lsb_to_mc_wr;
  logic [ADDR_WIDTH-1:0] lsb_to_mc_addr;
  logic [1:0]            lsb_to_mc_len;
  logic [31:0]           lsb_to_mc_data;
  logic                  mc_to_lsb_ready;
  logic [31:0]           mc_to_lsb_data;

  modport master (
    input  mem_din, io_buffer_full,
    input  if_to_mc_ready, if_to_mc_PC,
    input  lsb_to_mc_valid, lsb_to_mc_wr, lsb_to_mc_addr, lsb_to_mc_len, lsb_to_mc_data,
    output mem_dout, mem_a, mem_wr,
    output mc_to_if_ready, mc_to_if_inst,
    output mc_to_lsb_ready, mc_to_lsb_data
  );

  modport slave (
    output mem_din, io_buffer_full,
    output if_to_mc_ready, if_to_mc_PC,
    output lsb_to_mc_valid, lsb_to_mc_wr, lsb_to_mc_addr, lsb_to_mc_len, lsb_to_mc_data,
    input  mem_dout, mem_a, mem_wr,
    input  mc_to_if_ready, mc_to_if_inst,
    input  mc_to_lsb_ready, mc_to_lsb_data
  );
endinterface

// File: rtl/memory_controller.sv
// rtl/memory_controller.sv - arbitrates fetcher and LSB onto the byte-wide RAM/IO port
// Ports:
//   clk_in  : single clock
//   rst_in  : asynchronous reset, active-high
//   rdy_in  : global enable, 0 freezes all state and blocks writes
//   clr_in  : misprediction flush, aborts reads and blocks a grant in IDLE
//   bus     : memory_controller_if.master (RAM port, fetch and LSB handshakes)
module memory_controller
  import memory_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int IO_SEL_HI  = 17,
  parameter int IO_SEL_LO  = 16
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                clr_in,
  memory_controller_if.master bus
);

  mc_state_t             state, state_n;
  grant_t                last_grant, last_grant_n;
  logic [2:0]            cnt, cnt_n;
  logic [2:0]            nbytes, nbytes_n;
  logic [ADDR_WIDTH-1:0] base, base_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [31:0]           wdata, wdata_n;
  logic [31:0]           lanes, lanes_n;
  logic [7:0]            dout_q, dout_n;
  logic                  wr_q, wr_n;
  logic                  if_rdy_q, if_rdy_n;
  logic                  lsb_rdy_q, lsb_rdy_n;
  INST_TYPE              inst_q, inst_n;
  logic [31:0]           ldata_q, ldata_n;

  logic                  stall;
  logic                  pick_if;
  logic [2:0]            cnt_p1;
  logic [ADDR_WIDTH-1:0] addr_p1;

  assign cnt_p1  = cnt + 3'd1;
  assign addr_p1 = base + ADDR_WIDTH'(cnt_p1);  // wraps mod 2^ADDR_WIDTH

  // The IO test uses the byte address currently on the port.
  assign stall = (state == LS_WRITE) && (&addr_q[IO_SEL_HI:IO_SEL_LO]) && bus.io_buffer_full;

  // Round-robin: the fetcher wins a tie only if the LSB was served last.
  assign pick_if = bus.if_to_mc_ready && (!bus.lsb_to_mc_valid || last_grant == GRANT_LSB);

  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    cnt_n        = cnt;
    nbytes_n     = nbytes;
    base_n       = base;
    addr_n       = addr_q;
    wdata_n      = wdata;
    lanes_n      = lanes;
    dout_n       = dout_q;
    wr_n         = wr_q;
    if_rdy_n     = FALSE;
    lsb_rdy_n    = FALSE;
    inst_n       = inst_q;
    ldata_n      = ldata_q;

    case (state)
      IDLE: begin
        // A pulse still on the outputs means its requester has not dropped valid yet.
        if (!if_rdy_q && !lsb_rdy_q && !clr_in) begin
          if (pick_if) begin
            state_n      = IF_READ;
            last_grant_n = GRANT_IF;
            base_n       = bus.if_to_mc_PC;
            addr_n       = bus.if_to_mc_PC;
            nbytes_n     = 3'd4;
            cnt_n        = 3'd0;
            lanes_n      = '0;
            wr_n         = FALSE;
          end else if (bus.lsb_to_mc_valid) begin
            state_n      = bus.lsb_to_mc_wr ? LS_WRITE : LS_READ;
            last_grant_n = GRANT_LSB;
            base_n       = bus.lsb_to_mc_addr;
            addr_n       = bus.lsb_to_mc_addr;
            nbytes_n     = len_to_bytes(bus.lsb_to_mc_len);
            wdata_n      = bus.lsb_to_mc_data;
            cnt_n        = 3'd0;
            lanes_n      = '0;
            wr_n         = bus.lsb_to_mc_wr;
            if (bus.lsb_to_mc_wr) dout_n = bus.lsb_to_mc_data[7:0];
          end
        end
      end

      IF_READ, LS_READ: begin
        if (clr_in) begin
          state_n = IDLE;
          cnt_n   = 3'd0;
        end else begin
          // While cnt = k, mem_din carries the byte addressed at count k-1.
          if (cnt != 3'd0) lanes_n[{cnt[1:0] - 2'd1, 3'b000} +: 8] = bus.mem_din;
          if (cnt == nbytes) begin
            state_n = IDLE;
            cnt_n   = 3'd0;
            if (state == IF_READ) begin
              if_rdy_n = TRUE;
              inst_n   = lanes_n;
            end else begin
              lsb_rdy_n = TRUE;
              ldata_n   = lanes_n;
            end
          end else begin
            cnt_n = cnt_p1;
            if (cnt_p1 != nbytes) addr_n = addr_p1;
          end
        end
      end

      LS_WRITE: begin
        // Stores are committed, so a flush does not interrupt them.
        if (!stall) begin
          if (cnt_p1 == nbytes) begin
            state_n   = IDLE;
            cnt_n     = 3'd0;
            wr_n      = FALSE;
            lsb_rdy_n = TRUE;
          end else begin
            cnt_n  = cnt_p1;
            addr_n = addr_p1;
            dout_n = wdata[{cnt_p1[1:0], 3'b000} +: 8];
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= IDLE;
      last_grant <= GRANT_LSB;
      cnt        <= 3'd0;
      nbytes     <= 3'd0;
      base       <= BLANK_ADDR[ADDR_WIDTH-1:0];
      addr_q     <= BLANK_ADDR[ADDR_WIDTH-1:0];
      wdata      <= '0;
      lanes      <= '0;
      dout_q     <= 8'h00;
      wr_q       <= FALSE;
      if_rdy_q   <= FALSE;
      lsb_rdy_q  <= FALSE;
      inst_q     <= '0;
      ldata_q    <= '0;
    end else if (rdy_in) begin
      state      <= state_n;
      last_grant <= last_grant_n;
      cnt        <= cnt_n;
      nbytes     <= nbytes_n;
      base       <= base_n;
      addr_q     <= addr_n;
      wdata      <= wdata_n;
      lanes      <= lanes_n;
      dout_q     <= dout_n;
      wr_q       <= wr_n;
      if_rdy_q   <= if_rdy_n;
      lsb_rdy_q  <= lsb_rdy_n;
      inst_q     <= inst_n;
      ldata_q    <= ldata_n;
    end
  end

  assign bus.mem_a           = addr_q;
  assign bus.mem_dout        = dout_q;
  assign bus.mem_wr          = wr_q && rdy_in && !stall;
  assign bus.mc_to_if_ready  = if_rdy_q;
  assign bus.mc_to_if_inst   = inst_q;
  assign bus.mc_to_lsb_ready = lsb_rdy_q;
  assign bus.mc_to_lsb_data  = ldata_q;

endmodule

// File: tb/tb_memory_controller.sv
// tb/tb_memory_controller.sv - self-checking bench for memory_controller with a behavioural memory model
module tb_memory_controller;
  import memory_controller_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  logic clr = 1'b0;

  memory_controller_if bus ();

  memory_controller dut (
    .clk_in (clk),
    .rst_in (rst),
    .rdy_in (rdy),
    .clr_in (clr),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // RAM driven by the DUT, and an independent reference image updated from requests.
  logic [7:0] ram     [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];
  int         wr_cycles = 0;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_rd(a + 32'(i));
    return v;
  endfunction

  task automatic ref_write(input logic [31:0] a, input int n, input logic [31:0] d);
    for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = d[8*i +: 8];
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    ram[a]     = b;
    ref_mem[a] = b;
  endtask

  // rdy_in is a system-wide enable, so the RAM model pauses with it.
  always @(posedge clk) begin
    if (rdy) begin
      bus.mem_din <= ram_rd(bus.mem_a);
      if (bus.mem_wr) begin
        ram[bus.mem_a] = bus.mem_dout;
        wr_cycles++;
      end
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Raise the chosen requests, wait (bounded) for each pulse, drop each on its pulse.
  // Latency k means the pulse appeared k cycles after the request cycle.
  task automatic serve(input bit do_if, input bit do_lsb,
                       output int if_lat, output int lsb_lat,
                       output logic [31:0] inst, output logic [31:0] ldata);
    bit if_pend  = do_if;
    bit lsb_pend = do_lsb;
    if_lat  = -1;
    lsb_lat = -1;
    inst    = '0;
    ldata   = '0;
    bus.if_to_mc_ready  = do_if;
    bus.lsb_to_mc_valid = do_lsb;
    for (int k = 1; k <= 60 && (if_pend || lsb_pend); k++) begin
      tick();
      if (if_pend && bus.mc_to_if_ready) begin
        if_pend = 1'b0; if_lat = k; inst = bus.mc_to_if_inst;
        bus.if_to_mc_ready = 1'b0;
      end
      if (lsb_pend && bus.mc_to_lsb_ready) begin
        lsb_pend = 1'b0; lsb_lat = k; ldata = bus.mc_to_lsb_data;
        bus.lsb_to_mc_valid = 1'b0;
      end
    end
    bus.if_to_mc_ready  = 1'b0;
    bus.lsb_to_mc_valid = 1'b0;
    tick();
    chk("pulse_width_if", bus.mc_to_if_ready, 0);
    chk("pulse_width_lsb", bus.mc_to_lsb_ready, 0);
  endtask

  task automatic set_lsb(input logic wr, input logic [31:0] a, input logic [1:0] len, input logic [31:0] d);
    bus.lsb_to_mc_wr   = wr;
    bus.lsb_to_mc_addr = a;
    bus.lsb_to_mc_len  = len;
    bus.lsb_to_mc_data = d;
  endtask

  initial begin
    int          if_lat, lsb_lat, exp_if_lat, exp_lsb_lat, n, w0;
    logic [31:0] inst, ldata, exp_inst, exp_ldata, pc, addr, d;
    logic [1:0]  len;
    logic        wr;
    bit          exp_last_if, kind_if, kind_lsb, first_if;
    logic [1:0]  lens [3] = '{2'd0, 2'd1, 2'd3};

    bus.if_to_mc_ready = 1'b0;
    bus.if_to_mc_PC    = '0;
    bus.lsb_to_mc_valid = 1'b0;
    set_lsb(1'b0, '0, 2'd0, '0);
    bus.io_buffer_full = 1'b0;

    // Reset values
    #1;
    chk("rst_mem_a", bus.mem_a, 0);
    chk("rst_mem_wr", bus.mem_wr, 0);
    chk("rst_mem_dout", bus.mem_dout, 0);
    chk("rst_if_ready", bus.mc_to_if_ready, 0);
    chk("rst_lsb_ready", bus.mc_to_lsb_ready, 0);
    chk("rst_if_inst", bus.mc_to_if_inst, 0);
    chk("rst_lsb_data", bus.mc_to_lsb_data, 0);
    tick();
    rst = 1'b0;

    // Fetch of 13 05 00 00 at 0x1000
    preload(32'h1000, 8'h13); preload(32'h1001, 8'h05);
    preload(32'h1002, 8'h00); preload(32'h1003, 8'h00);
    preload(32'h10, 8'h80);
    bus.if_to_mc_PC = 32'h1000;
    bus.if_to_mc_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k <= 4) chk($sformatf("if_addr_%0d", k), bus.mem_a, 32'h1000 + k - 1);
      chk($sformatf("if_wr_%0d", k), bus.mem_wr, 0);
      chk($sformatf("if_ready_%0d", k), bus.mc_to_if_ready, (k == 6));
    end
    chk("if_inst", bus.mc_to_if_inst, 32'h0000_0513);
    bus.if_to_mc_ready = 1'b0;
    tick();
    chk("if_pulse_width", bus.mc_to_if_ready, 0);
    chk("if_inst_hold", bus.mc_to_if_inst, 32'h0000_0513);

    // Word store of DEADBEEF at 0x200
    d = 32'hDEAD_BEEF;
    set_lsb(1'b1, 32'h200, LEN_W, d);
    bus.lsb_to_mc_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k <= 4) begin
        chk($sformatf("st_wr_%0d", k), bus.mem_wr, 1);
        chk($sformatf("st_addr_%0d", k), bus.mem_a, 32'h200 + k - 1);
        chk($sformatf("st_dout_%0d", k), bus.mem_dout, d[8*(k-1) +: 8]);
      end else begin
        chk("st_wr_done", bus.mem_wr, 0);
      end
      chk($sformatf("st_ready_%0d", k), bus.mc_to_lsb_ready, (k == 5));
    end
    bus.lsb_to_mc_valid = 1'b0;
    ref_write(32'h200, 4, d);
    tick();

    // Simultaneous fetch and byte load from reset: fetch first, then the load
    do_reset();
    set_lsb(1'b0, 32'h10, LEN_B, '0);
    serve(1'b1, 1'b1, if_lat, lsb_lat, inst, ldata);
    chk("both_if_lat", if_lat, 6);
    chk("both_if_inst", inst, 32'h0000_0513);
    chk("both_lsb_lat", lsb_lat, 6 + 1 + 3);
    chk("both_lsb_data", ldata, 32'h0000_0080);

    // IO store stalled by a full UART buffer for three cycles
    set_lsb(1'b1, 32'h0003_0000, LEN_B, 32'h41);
    bus.io_buffer_full  = 1'b1;
    bus.lsb_to_mc_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("io_stall_wr_%0d", k), bus.mem_wr, 0);
      chk($sformatf("io_stall_addr_%0d", k), bus.mem_a, 32'h0003_0000);
      chk($sformatf("io_stall_ready_%0d", k), bus.mc_to_lsb_ready, 0);
    end
    tick();
    bus.io_buffer_full = 1'b0;
    #1;
    chk("io_resume_wr", bus.mem_wr, 1);
    chk("io_resume_dout", bus.mem_dout, 8'h41);
    tick();
    chk("io_ready", bus.mc_to_lsb_ready, 1);
    chk("io_wr_after", bus.mem_wr, 0);
    bus.lsb_to_mc_valid = 1'b0;
    ref_write(32'h0003_0000, 1, 32'h41);
    tick();
    chk("io_ram", ram_rd(32'h0003_0000), 8'h41);

    // Flush during fetch byte 2, held one more cycle while the next request is already up
    bus.if_to_mc_PC = 32'h1000;
    bus.if_to_mc_ready = 1'b1;
    tick(); tick(); tick();
    chk("clr_byte2_addr", bus.mem_a, 32'h1002);
    clr = 1'b1;
    bus.if_to_mc_PC = 32'h200;
    tick();
    chk("clr_no_ready_a", bus.mc_to_if_ready, 0);
    tick();
    clr = 1'b0;
    chk("clr_no_ready_b", bus.mc_to_if_ready, 0);
    chk("clr_no_grant", bus.mem_a, 32'h1002);
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) chk("clr_restart_addr", bus.mem_a, 32'h200);
      chk($sformatf("clr_ready_%0d", k), bus.mc_to_if_ready, (k == 6));
    end
    chk("clr_refetch_inst", bus.mc_to_if_inst, ref_read(32'h200, 4));
    bus.if_to_mc_ready = 1'b0;
    tick();

    // rdy_in low for two cycles in the middle of a word load
    set_lsb(1'b0, 32'h200, LEN_W, '0);
    bus.lsb_to_mc_valid = 1'b1;
    tick();
    chk("rdy_addr_1", bus.mem_a, 32'h200);
    tick();
    chk("rdy_addr_2", bus.mem_a, 32'h201);
    rdy = 1'b0;
    tick();
    chk("rdy_addr_frozen_a", bus.mem_a, 32'h201);
    chk("rdy_ready_frozen", bus.mc_to_lsb_ready, 0);
    tick();
    chk("rdy_addr_frozen_b", bus.mem_a, 32'h201);
    rdy = 1'b1;
    for (int k = 5; k <= 8; k++) begin
      tick();
      if (k == 5) chk("rdy_addr_resume", bus.mem_a, 32'h202);
      chk($sformatf("rdy_ready_%0d", k), bus.mc_to_lsb_ready, (k == 8));
    end
    chk("rdy_load_data", bus.mc_to_lsb_data, 32'hDEAD_BEEF);
    bus.lsb_to_mc_valid = 1'b0;
    tick();

    // rdy_in low blocks a store byte
    set_lsb(1'b1, 32'h300, LEN_B, 32'h5A);
    bus.lsb_to_mc_valid = 1'b1;
    tick();
    chk("rdy_st_wr_on", bus.mem_wr, 1);
    rdy = 1'b0;
    #1;
    chk("rdy_st_wr_forced", bus.mem_wr, 0);
    tick();
    chk("rdy_st_wr_held", bus.mem_wr, 0);
    rdy = 1'b1;
    #1;
    chk("rdy_st_wr_back", bus.mem_wr, 1);
    tick();
    chk("rdy_st_ready", bus.mc_to_lsb_ready, 1);
    bus.lsb_to_mc_valid = 1'b0;
    ref_write(32'h300, 1, 32'h5A);
    tick();

    // Randomized traffic against the reference image
    do_reset();
    exp_last_if = 1'b0;
    for (int it = 0; it < 40; it++) begin
      kind_if  = ($urandom_range(0, 2) != 1);
      kind_lsb = !kind_if || ($urandom_range(0, 1) == 1);
      pc   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                         : 32'h400 + 32'($urandom_range(0, 63));
      addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                         : 32'h400 + 32'($urandom_range(0, 63));
      len  = lens[$urandom_range(0, 2)];
      wr   = 1'($urandom_range(0, 1));
      d    = $urandom;
      n    = (len == LEN_B) ? 1 : (len == LEN_H) ? 2 : 4;
      bus.if_to_mc_PC = pc;
      set_lsb(wr, addr, len, d);

      first_if    = kind_if && (!kind_lsb || !exp_last_if);
      exp_if_lat  = -1;
      exp_lsb_lat = -1;
      exp_inst    = '0;
      exp_ldata   = '0;
      if (first_if) begin
        exp_if_lat = 6;
        exp_inst   = ref_read(pc, 4);
        if (kind_lsb) exp_lsb_lat = 7 + (wr ? n + 1 : n + 2);
      end else begin
        exp_lsb_lat = wr ? n + 1 : n + 2;
        if (kind_if) exp_if_lat = exp_lsb_lat + 7;
      end
      if (kind_lsb) begin
        if (!wr) exp_ldata = ref_read(addr, n);
        else     ref_write(addr, n, d);
      end
      if (kind_if && !first_if) exp_inst = ref_read(pc, 4);
      exp_last_if = kind_lsb ? !first_if && kind_if : 1'b1;
      if (kind_lsb && first_if) exp_last_if = 1'b0;

      w0 = wr_cycles;
      serve(kind_if, kind_lsb, if_lat, lsb_lat, inst, ldata);
      chk($sformatf("rnd%0d_wr_cycles", it), wr_cycles - w0, (kind_lsb && wr) ? n : 0);
      if (kind_if) begin
        chk($sformatf("rnd%0d_if_lat", it), if_lat, exp_if_lat);
        chk($sformatf("rnd%0d_if_inst", it), inst, exp_inst);
      end
      if (kind_lsb) begin
        chk($sformatf("rnd%0d_lsb_lat", it), lsb_lat, exp_lsb_lat);
        if (!wr) chk($sformatf("rnd%0d_lsb_data", it), ldata, exp_ldata);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_controller.md
Name: memory_controller

Overview:
- Sole owner of the single byte-wide RAM/IO port.
- Arbitrates between two requesters:
  - the instruction fetcher: 4-byte instruction reads;
  - the load/store buffer (LSB): 1/2/4-byte loads and stores.
- Serialises each request into per-byte RAM cycles, reassembles read bytes little-endian, and returns a one-cycle ready pulse to the granted requester.

Parameters:
- ADDR_WIDTH, 32, address width of the RAM port and of the requests.
- IO_SEL_HI, 17, MSB of the address field that selects the IO region.
- IO_SEL_LO, 16, LSB of that field; a value of 2'b11 in addr[IO_SEL_HI:IO_SEL_LO] means IO.

Ports:
- clk_in  in  1  single clock
- rst_in  in  1  asynchronous reset, active-high
- rdy_in  in  1  global enable; 0 freezes all state
- clr_in  in  1  ROB misprediction flush
- mem_din  in  8  RAM read byte; valid one cycle after its address
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  1 = write this cycle
- io_buffer_full  in  1  IO UART buffer full; stalls IO writes
- if_to_mc_ready  in  1  fetch request valid (level)
- if_to_mc_PC  in  32  fetch address
- mc_to_if_ready  out  1  fetch done pulse
- mc_to_if_inst  out  32  fetched instruction
- lsb_to_mc_valid  in  1  LSB request valid (level)
- lsb_to_mc_wr  in  1  1 = store, 0 = load
- lsb_to_mc_addr  in  32  byte address
- lsb_to_mc_len  in  2  byte count: 0=1, 1=2, 3=4 (2 is illegal)
- lsb_to_mc_data  in  32  store data, low bytes first
- mc_to_lsb_ready  out  1  LSB done pulse
- mc_to_lsb_data  out  32  load data, zero-extended raw bytes

Behaviour:
- Reset (async, rst_in=1): state=IDLE, byte counter=0, last_grant=LSB; every output 0, including mem_wr, mem_a and the ready pulses.
- rdy_in=0: no state change, mem_wr forced 0, outputs otherwise held.
- States: IDLE, IF_READ, LS_READ, LS_WRITE.
- IDLE grant rules:
  - No grant in a cycle where a ready pulse is being driven. Requesters drop valid on seeing ready.
  - Both requesting: round-robin; grant the one not equal to last_grant.
  - Otherwise grant the single requester.
- On grant, latch base address, N (4 for IF), store data and direction. Update last_grant.
- Read (grant sampled at cycle t):
  - byte k address on mem_a in cycle t+1+k, k=0..N-1;
  - mem_din captured into byte lane k in cycle t+2+k;
  - ready pulse plus data visible in cycle t+2+N, state back to IDLE.
  - A 4-byte read therefore pulses ready at t+6.
  - Unused upper lanes are 0.
- Write:
  - byte k on mem_dout with mem_a=base+k and mem_wr=1 in cycle t+1+k;
  - ready pulse in cycle t+1+N.
- IO stall: during LS_WRITE, if the address is in the IO region and io_buffer_full=1, mem_wr=0 and the counter holds. Resume when io_buffer_full returns to 0.
- mem_wr is 0 in every state except an active, unstalled LS_WRITE byte.
- Ready pulses are exactly one cycle wide; data outputs hold until the next completion.
- clr_in=1:
  - IF_READ and LS_READ abort: IDLE next cycle, no ready pulse, counter cleared.
  - LS_WRITE continues to completion and still pulses ready, because stores are committed.
  - A request sampled in IDLE in the same cycle is not granted.
- Address arithmetic: base+k is a 32-bit add and wraps mod 2^32.

Decomposition:
- Shared header holds:
  - ADDR_TYPE, INST_TYPE, BLANK_ADDR, TRUE/FALSE;
  - the length encoding constants LEN_B/LEN_H/LEN_W;
  - the controller state encodings.
- No sub-module. Byte-lane assembly is a counter-indexed register write inside this block.

Test Plan:
- IF only, PC=0x00001000, RAM bytes 13 05 00 00 -> mem_a 0x1000..0x1003 on consecutive cycles; mc_to_if_inst=0x00000513 with one-cycle pulse 6 cycles after the grant cycle.
- LSB store len=3, addr=0x200, data=0xDEADBEEF -> mem_wr=1 for 4 cycles with mem_dout EF,BE,AD,DE at 0x200..0x203; mc_to_lsb_ready pulses 5 cycles after grant.
- IF and LSB load (len=0, addr=0x10, byte 0x80) requesting together from reset -> IF granted first. After the IF pulse, the LSB is served; mc_to_lsb_data=0x00000080.
- Store byte 0x41 to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr stays 0 for those cycles, then one write cycle, then the ready pulse.
- clr_in asserted during IF_READ byte 2 -> no mc_to_if_ready, IDLE next cycle; the next fetch request starts cleanly at byte 0.
- rdy_in=0 for 2 cycles mid-load -> mem_a and counter frozen, completion delayed by exactly 2 cycles.
